// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the MIPS control/datapath and the
// multiply/divide unit. The issuer drives the request side (master),
// the unit drives busy/done and the HI/LO pair (slave).
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             clk_enable;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output clk_enable, start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  clk_enable, start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Signed operations are
// reduced to unsigned magnitudes at accept time, iterated one bit per
// cycle (shift-add multiply, restoring divide), and sign-corrected in a
// final commit cycle. MTHI/MTLO write HI/LO directly from IDLE.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mips_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_mul;
  logic               res_neg;
  logic               rem_neg;
  logic               div_zero;
  // Multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]   addend;
  // Raw dividend, needed for the divide-by-zero HI value
  logic [WIDTH-1:0]   src_a;
  // Multiply: {partial product, remaining multiplier bits}
  // Divide: low half holds dividend bits shifting out / quotient shifting in
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes and signs for a request arriving this cycle;
  // MIN negates to itself, which is its correct unsigned magnitude
  always_comb begin
    a_neg    = ~bus.op[0] & bus.operand_a[WIDTH-1];
    b_neg    = ~bus.op[0] & bus.operand_b[WIDTH-1];
    mag_a_in = a_neg ? -bus.operand_a : bus.operand_a;
    mag_b_in = b_neg ? -bus.operand_b : bus.operand_b;
  end

  // One iteration of each algorithm; the trial remainder is WIDTH+1 bits
  // wide, and whenever it is kept or reduced the result fits in WIDTH bits
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_trial = {rem, acc[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, addend};
    div_diff  = div_trial[WIDTH-1:0] - addend;
  end

  // Sign correction applied in the commit cycle
  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quot_fix = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? -rem : rem;
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_mul   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      addend   <= '0;
      src_a    <= '0;
      acc      <= '0;
      rem      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else if (bus.clk_enable) begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                is_mul   <= 1'b1;
                addend   <= mag_a_in;
                acc      <= {{WIDTH{1'b0}}, mag_b_in};
                rem      <= '0;
                res_neg  <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
                div_zero <= 1'b0;
                src_a    <= bus.operand_a;
                count    <= CW'(WIDTH);
                busy_q   <= 1'b1;
                state    <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                is_mul   <= 1'b0;
                addend   <= mag_b_in;
                acc      <= {{WIDTH{1'b0}}, mag_a_in};
                rem      <= '0;
                res_neg  <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
                div_zero <= (bus.operand_b == '0);
                src_a    <= bus.operand_a;
                count    <= CW'(WIDTH);
                busy_q   <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: hi_q <= bus.operand_a;
              OP_MTLO: lo_q <= bus.operand_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_mul) begin
            if (acc[0]) begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end else begin
              acc <= {1'b0, acc[2*WIDTH-1:1]};
            end
          end else begin
            rem <= div_ge ? div_diff : div_trial[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_mul) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= src_a;
            lo_q <= '1;
            dz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit. A transaction-level model
// (plain 64-bit arithmetic plus a latency countdown in enabled edges)
// is compared against the WIDTH=32 unit every cycle; directed cases pin
// the model with hand-computed values, and a WIDTH=8 instance covers the
// narrow MIN x MIN multiply.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  mips_muldiv_unit_if #(.WIDTH(32)) bus ();
  mips_muldiv_unit_if #(.WIDTH(8))  bus8 ();

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Reference model state
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  logic        p_dz   = 1'b0;
  int          m_left = 0;

  // Architectural result of a mul/div operation
  function automatic void compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint          sa;
    longint          sb;
    longint          sp;
    longint unsigned up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      3'd0: begin
        sp = sa * sb;
        rh = sp[63:32];
        rl = sp[31:0];
      end
      3'd1: begin
        up = {32'h0, a} * {32'h0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 32'h0) begin
          rh  = a;
          rl  = 32'hFFFF_FFFF;
          rdz = 1'b1;
        end else if (o == 3'd2) begin
          rl = 32'(sa / sb);
          rh = 32'(sa % sb);
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Model: results appear WIDTH+1 enabled edges after a mul/div accept
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else if (bus.clk_enable) begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_dz   = p_dz;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (bus.start) begin
        case (bus.op)
          3'd4: m_hi = bus.operand_a;
          3'd5: m_lo = bus.operand_a;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            compute(bus.op, bus.operand_a, bus.operand_b, p_hi, p_lo, p_dz);
            m_left = W + 1;
            m_busy = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !==
          {m_busy, m_done, m_dz, m_hi, m_lo}) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t busy/done/dbz/hi/lo actual %b %b %b %h %h required %b %b %b %h %h",
                 $time, bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo,
                 m_busy, m_done, m_dz, m_hi, m_lo);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual %h required %h", name, actual, expected);
    end
  endtask

  // One-cycle request on the 32-bit unit; returns on the first cycle after accept
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = o;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait for done, measuring latency and busy cycles from the accept edge
  task automatic waitResult(output int lat, output int busy_cyc, output logic dz_seen);
    bit got;
    got      = 1'b0;
    lat      = 0;
    dz_seen  = 1'b0;
    busy_cyc = bus.busy ? 1 : 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        got     = 1'b1;
        dz_seen = bus.div_by_zero;
      end else if (bus.busy) begin
        busy_cyc++;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done-timeout actual none required done within 200 cycles");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual still running required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   bcyc;
    logic dz;
    int   done_cnt;
    bit   got;

    reset           = 1'b1;
    bus.clk_enable  = 1'b1;
    bus.start       = 1'b0;
    bus.op          = '0;
    bus.operand_a   = '0;
    bus.operand_b   = '0;
    bus8.clk_enable = 1'b1;
    bus8.start      = 1'b0;
    bus8.op         = '0;
    bus8.operand_a  = '0;
    bus8.operand_b  = '0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_on = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset hi", bus.hi, 32'h0);
    checkOutput("reset lo", bus.lo, 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    checkOutput("reset done", 32'(bus.done), 32'h0);

    $display("[TB] WIDTH=8 MULT -128 x -128");
    @(negedge clk);
    bus8.start     = 1'b1;
    bus8.op        = 3'd0;
    bus8.operand_a = 8'h80;
    bus8.operand_b = 8'h80;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      lat = i;
      if (bus8.done) got = 1'b1;
    end
    checkOutput("w8 latency", 32'(lat), 32'd9);
    checkOutput("w8 hi", 32'(bus8.hi), 32'h40);
    checkOutput("w8 lo", 32'(bus8.lo), 32'h00);

    $display("[TB] MULT -3 x 5");
    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    waitResult(lat, bcyc, dz);
    checkOutput("mult latency", 32'(lat), 32'd33);
    checkOutput("mult busy cycles", 32'(bcyc), 32'd33);
    checkOutput("mult hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult lo", bus.lo, 32'hFFFF_FFF1);

    $display("[TB] MULTU max x max");
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult(lat, bcyc, dz);
    checkOutput("multu hi", bus.hi, 32'hFFFF_FFFE);
    checkOutput("multu lo", bus.lo, 32'h0000_0001);

    $display("[TB] DIV -7 / 2");
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    waitResult(lat, bcyc, dz);
    checkOutput("div latency", 32'(lat), 32'd33);
    checkOutput("div lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("div hi", bus.hi, 32'hFFFF_FFFF);

    $display("[TB] DIV MIN / -1");
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult(lat, bcyc, dz);
    checkOutput("div min lo", bus.lo, 32'h8000_0000);
    checkOutput("div min hi", bus.hi, 32'h0000_0000);

    $display("[TB] DIVU 5 / 0");
    applyStimulus(3'd3, 32'h0000_0005, 32'h0000_0000);
    waitResult(lat, bcyc, dz);
    checkOutput("divu0 flag", 32'(dz), 32'h1);
    checkOutput("divu0 hi", bus.hi, 32'h0000_0005);
    checkOutput("divu0 lo", bus.lo, 32'hFFFF_FFFF);

    $display("[TB] MTHI / MTLO");
    applyStimulus(3'd4, 32'h1234_5678, 32'h0);
    checkOutput("mthi hi", bus.hi, 32'h1234_5678);
    checkOutput("mthi busy", 32'(bus.busy), 32'h0);
    applyStimulus(3'd5, 32'h9ABC_DEF0, 32'h0);
    checkOutput("mtlo lo", bus.lo, 32'h9ABC_DEF0);
    checkOutput("mtlo hi kept", bus.hi, 32'h1234_5678);
    checkOutput("mtlo busy", 32'(bus.busy), 32'h0);

    $display("[TB] MULTU 7 x 6 with clk_enable stall and ignored start");
    applyStimulus(3'd1, 32'd7, 32'd6);
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      lat = c;
      if (bus.done) got = 1'b1;
      if (c == 3) begin
        bus.start     = 1'b1;
        bus.op        = 3'd3;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd3;
      end
      if (c == 4)  bus.start = 1'b0;
      if (c == 10) bus.clk_enable = 1'b0;
      if (c == 15) bus.clk_enable = 1'b1;
    end
    checkOutput("stall latency", 32'(lat), 32'd38);
    checkOutput("stall hi", bus.hi, 32'h0);
    checkOutput("stall lo", bus.lo, 32'h0000_002A);

    $display("[TB] reset during DIVU");
    applyStimulus(3'd3, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort hi", bus.hi, 32'h0);
    checkOutput("abort lo", bus.lo, 32'h0);
    checkOutput("abort busy", 32'(bus.busy), 32'h0);
    checkOutput("abort done", 32'(bus.done), 32'h0);
    checkOutput("abort dbz", 32'(bus.div_by_zero), 32'h0);
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checkOutput("abort no done", 32'(done_cnt), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      bus.clk_enable = ($urandom_range(7) != 0);
      bus.start      = ($urandom_range(3) == 0);
      bus.op         = 3'($urandom_range(7));
      bus.operand_a  = pick();
      bus.operand_b  = pick();
      reset          = ($urandom_range(1999) == 0);
    end
    @(negedge clk);
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.clk_enable = 1'b1;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
